// File: rtl/sc_ifu_pkg.sv
// Shared types and constants for the single-cycle MIPS instruction-fetch unit.
package sc_ifu_pkg;

    // Fetch sequencer states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } ifu_state_e;

    // Next-PC select encodings driven by the control unit.
    localparam logic [1:0] PC_SEQ = 2'b00;
    localparam logic [1:0] PC_BR  = 2'b01;
    localparam logic [1:0] PC_JR  = 2'b10;
    localparam logic [1:0] PC_J   = 2'b11;

    // Instruction addresses are always word aligned.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/sc_npc.sv
// Combinational next-PC selector with word-alignment masking.
module sc_npc
    import sc_ifu_pkg::*;
(
    input  logic [1:0]  pcsource,
    input  logic [31:0] pc4,
    input  logic [31:0] bpc,
    input  logic [31:0] ra,
    input  logic [31:0] jpc,
    output logic [31:0] npc
);

    logic [31:0] npc_raw;

    // Pick the raw target requested by decode.
    always_comb begin
        // NOTE: default first so every path assigns npc_raw and no latch is inferred.
        npc_raw = pc4;
        case (pcsource)
            PC_SEQ:  npc_raw = pc4;
            PC_BR:   npc_raw = bpc;
            PC_JR:   npc_raw = ra;
            PC_J:    npc_raw = jpc;
            default: npc_raw = pc4;
        endcase
    end

    // A jr through a misaligned register must still land on a word boundary.
    assign npc = word_align(npc_raw);

endmodule

// File: rtl/sc_ifu.sv
// Instruction-fetch unit: owns the PC, fetches one word per instruction over a
// req/ack handshake and holds it for decode until the core retires it.
module sc_ifu
    import sc_ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned MAX_WAIT = 16
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [1:0]  pcsource,
    input  logic [31:0] bpc,
    input  logic [31:0] jpc,
    input  logic [31:0] ra,
    input  logic        exec_done,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic        inst_valid,
    output logic [31:0] pc,
    output logic [31:0] pc4,
    output logic        fetch_err
);

    localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

    ifu_state_e  state_q, state_d;
    logic [31:0] pc_q;
    logic [31:0] inst_q;
    logic        inst_valid_q;
    logic [7:0]  wait_cnt_q;
    logic        fetch_err_q;
    logic [31:0] npc;

    logic fetch_done;   // word accepted this cycle
    logic retire;       // current instruction done, advance PC
    logic req_stall;    // request outstanding with no ack
    logic req_entry;    // next cycle is the first of a new request

    assign fetch_done = (state_q == REQ)  && imem_ack;
    assign retire     = (state_q == HOLD) && exec_done;
    assign req_stall  = (state_q == REQ)  && !imem_ack;
    assign req_entry  = (state_d == REQ)  && (state_q != REQ);

    sc_npc u_npc (
        .pcsource (pcsource),
        .pc4      (pc4),
        .bpc      (bpc),
        .ra       (ra),
        .jpc      (jpc),
        .npc      (npc)
    );

    // State register.
    always_ff @(posedge clock or negedge resetn) begin
        // NOTE: sequential state uses <= so every register sees pre-edge values.
        if (!resetn) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic: IDLE -> REQ -> HOLD -> REQ ...
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = REQ;
            REQ:     if (imem_ack)  state_d = HOLD;
            HOLD:    if (exec_done) state_d = REQ;
            default: state_d = IDLE;
        endcase
    end

    // Program counter advances only when the held instruction retires.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)     pc_q <= RESET_PC;
        else if (retire) pc_q <= npc;
    end

    // Instruction latch and its valid flag.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            inst_q       <= 32'h0;
            inst_valid_q <= 1'b0;
        end else if (fetch_done) begin
            inst_q       <= imem_rdata;
            inst_valid_q <= 1'b1;
        end else if (retire) begin
            inst_valid_q <= 1'b0;
        end
    end

    // Saturating count of un-acked request cycles, restarted per request.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)
            wait_cnt_q <= 8'h0;
        else if (req_entry)
            wait_cnt_q <= 8'h0;
        else if (req_stall && (wait_cnt_q != MAX_WAIT_C))
            wait_cnt_q <= wait_cnt_q + 8'd1;
    end

    // Sticky timeout flag, set on the stall cycle that reaches the limit.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)
            fetch_err_q <= 1'b0;
        else if (req_stall && ((wait_cnt_q + 8'd1) == MAX_WAIT_C))
            fetch_err_q <= 1'b1;
    end

    assign imem_req   = (state_q == REQ);
    assign imem_addr  = pc_q;
    assign inst       = inst_q;
    assign inst_valid = inst_valid_q;
    assign pc         = pc_q;
    assign pc4        = pc_q + 32'd4;
    assign fetch_err  = fetch_err_q;

endmodule

// File: tb/tb_sc_ifu.sv
// Self-checking bench for sc_ifu: scoreboard of expected fetches popped as
// each instruction becomes valid, plus directed checks of handshake corners.
module tb_sc_ifu;
    import sc_ifu_pkg::*;

    logic        clock = 1'b0;
    logic        resetn;
    logic [1:0]  pcsource;
    logic [31:0] bpc, jpc, ra;
    logic        exec_done;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] inst;
    logic        inst_valid;
    logic [31:0] pc, pc4;
    logic        fetch_err;
    logic [31:0] rdata_xor;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];

    sc_ifu #(.RESET_PC(32'h0000_0000), .MAX_WAIT(4)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .pcsource   (pcsource),
        .bpc        (bpc),
        .jpc        (jpc),
        .ra         (ra),
        .exec_done  (exec_done),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .inst       (inst),
        .inst_valid (inst_valid),
        .pc         (pc),
        .pc4        (pc4),
        .fetch_err  (fetch_err)
    );

    always #5 clock = ~clock;

    // Instruction memory contents as a function of address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    // Memory model; rdata_xor lets a test corrupt the bus to prove it is ignored.
    always_comb imem_rdata = mem_word(imem_addr) ^ rdata_xor;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Wait (bounded) for inst_valid, then pop the scoreboard and compare.
    task automatic wait_fetch(input int exp_lat);
        int   n = 0;
        exp_t e;
        while (!inst_valid && n < 20) begin
            tick();
            n++;
        end
        if (!inst_valid) begin
            check("fetch_timeout", 32'(inst_valid), 32'd1);
        end else if (sb.size() == 0) begin
            check("sb_empty", 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            check("fetch_pc", pc, e.addr);
            check("fetch_inst", inst, e.data);
            if (exp_lat >= 0) check("fetch_lat", 32'(n), 32'(exp_lat));
        end
    endtask

    // Retire the held instruction and check the redirected request.
    task automatic retire(input logic [1:0] src, input logic [31:0] exp_addr);
        exp_t e;
        pcsource  = src;
        exec_done = 1'b1;
        tick();
        exec_done = 1'b0;
        check("req_after_done", 32'(imem_req), 32'd1);
        check("addr_after_done", imem_addr, exp_addr);
        check("valid_drop", 32'(inst_valid), 32'd0);
        e.addr = exp_addr;
        e.data = mem_word(exp_addr);
        sb.push_back(e);
    endtask

    initial begin
        exp_t e;
        resetn    = 1'b0;
        pcsource  = PC_SEQ;
        bpc       = 32'h0;
        jpc       = 32'h0;
        ra        = 32'h0;
        exec_done = 1'b0;
        imem_ack  = 1'b1;
        rdata_xor = 32'h0;

        // Reset values.
        #12;
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_pc", pc, 32'h0);
        check("rst_pc4", pc4, 32'h4);
        check("rst_inst", inst, 32'h0);
        check("rst_valid", 32'(inst_valid), 32'd0);
        check("rst_err", 32'(fetch_err), 32'd0);

        // First fetch with ack tied high.
        tick();
        resetn = 1'b1;
        tick();
        check("first_req", 32'(imem_req), 32'd1);
        check("first_addr", imem_addr, 32'h0);
        e.addr = 32'h0;
        e.data = mem_word(32'h0);
        sb.push_back(e);
        wait_fetch(1);

        // Ack in HOLD with different data must not disturb inst.
        rdata_xor = 32'hDEAD_BEEF;
        tick();
        check("hold_ack_inst", inst, mem_word(32'h0));
        check("hold_req_low", 32'(imem_req), 32'd0);
        rdata_xor = 32'h0;

        // Sequential flow from 0x10.
        bpc = 32'h0000_0010;
        retire(PC_BR, 32'h0000_0010);
        wait_fetch(1);
        retire(PC_SEQ, 32'h0000_0014);
        wait_fetch(1);

        // Each redirect source, including a misaligned jr target.
        bpc = 32'h0000_0100;
        ra  = 32'h0000_0203;
        jpc = 32'h0000_0400;
        retire(PC_BR, 32'h0000_0100);
        wait_fetch(1);
        retire(PC_JR, 32'h0000_0200);
        wait_fetch(1);
        retire(PC_J, 32'h0000_0400);
        wait_fetch(1);

        // pc4 wraps at the top of the address space.
        jpc = 32'hFFFF_FFFC;
        retire(PC_J, 32'hFFFF_FFFC);
        wait_fetch(1);
        check("pc4_wrap", pc4, 32'h0);
        retire(PC_SEQ, 32'h0000_0000);
        wait_fetch(1);

        // exec_done while a request is outstanding is ignored.
        imem_ack = 1'b0;
        bpc = 32'h0000_0020;
        retire(PC_BR, 32'h0000_0020);
        jpc       = 32'h0000_0800;
        pcsource  = PC_J;
        exec_done = 1'b1;
        tick();
        exec_done = 1'b0;
        check("req_done_pc", pc, 32'h0000_0020);
        check("req_done_req", 32'(imem_req), 32'd1);
        imem_ack = 1'b1;
        wait_fetch(1);
        check("no_err_short", 32'(fetch_err), 32'd0);

        // Stalled memory: six un-acked cycles against a limit of four.
        imem_ack = 1'b0;
        retire(PC_SEQ, 32'h0000_0024);
        check("stall_err0", 32'(fetch_err), 32'd0);
        for (int k = 1; k <= 6; k++) begin
            tick();
            check($sformatf("stall_req%0d", k), 32'(imem_req), 32'd1);
            check($sformatf("stall_err%0d", k), 32'(fetch_err), (k >= 4) ? 32'd1 : 32'd0);
        end
        imem_ack = 1'b1;
        wait_fetch(1);
        check("err_sticky", 32'(fetch_err), 32'd1);

        // Reset in the middle of a request.
        imem_ack = 1'b0;
        retire(PC_SEQ, 32'h0000_0028);
        tick();
        #2;
        resetn = 1'b0;
        #1;
        check("mid_rst_req", 32'(imem_req), 32'd0);
        check("mid_rst_pc", pc, 32'h0);
        check("mid_rst_valid", 32'(inst_valid), 32'd0);
        check("mid_rst_inst", inst, 32'h0);
        check("mid_rst_err", 32'(fetch_err), 32'd0);
        sb.delete();
        imem_ack = 1'b1;
        tick();
        tick();
        check("late_ack_valid", 32'(inst_valid), 32'd0);
        check("late_ack_inst", inst, 32'h0);
        resetn = 1'b1;
        tick();
        check("refetch_req", 32'(imem_req), 32'd1);
        check("refetch_addr", imem_addr, 32'h0);
        e.addr = 32'h0;
        e.data = mem_word(32'h0);
        sb.push_back(e);
        wait_fetch(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
